ftq_multi_commit: RTL and testbench
===================================

// Module: ftq_multi_commit
// PURPOSE
//  Parametrised fetch target queue between the BPU and the IFU. Holds predicted fetch blocks in
//  order and uses wrap-bit pointers (bpu/ifu/comm) so full and empty states are exact. Supports
//  main-BPU override of the youngest entry, with IFU rewind when that entry was already sent,
//  multi-slot in-order commit, and backend flush to a given FTQ id.
// PARAMETERS
//  DEPTH         8   entries; power of two, >=4
//  ADDR_WIDTH    32  PC width
//  LEN_WIDTH     3   fetch-block length field width
//  COMMIT_WIDTH  2   max blocks retired per cycle
//  ID_W = $clog2(DEPTH)+1 (derived): index + wrap bit
// PORTS
//  clk               in   1            clock
//  rst               in   1            synchronous, active-high reset
//  bpu_valid_i       in   1            enqueue new block (P0)
//  bpu_pc_i          in   ADDR_WIDTH   block start PC
//  bpu_len_i         in   LEN_WIDTH    block length
//  bpu_taken_i       in   1            predicted taken
//  bpu_ready_o       out  1            queue not full
//  bpu_ovr_valid_i   in   1            P1 override of youngest entry
//  bpu_ovr_pc_i      in   ADDR_WIDTH   override start PC
//  bpu_ovr_len_i     in   LEN_WIDTH    override length
//  bpu_ovr_taken_i   in   1            override taken
//  ifu_valid_o       out  1            entry at ifu_ptr is available
//  ifu_pc_o          out  ADDR_WIDTH   start PC at ifu_ptr
//  ifu_len_o         out  LEN_WIDTH    length at ifu_ptr
//  ifu_taken_o       out  1            taken flag at ifu_ptr
//  ifu_ftq_id_o      out  ID_W         ifu_ptr, including wrap bit
//  ifu_ready_i       in   1            IFU accepts the current entry
//  ifu_redirect_o    out  1            1-cycle pulse: drop the in-flight request
//  commit_mask_i     in   COMMIT_WIDTH retire bitmask; thermometer, bit0 first
//  flush_i           in   1            backend redirect
//  flush_id_i        in   ID_W         id of the redirecting block (kept)
//  count_o           out  ID_W         occupied entries, 0..DEPTH
// BEHAVIOUR
//  - Reset: all pointers 0; all entries invalid; bpu_ready_o=1; ifu_valid_o=0; ifu_redirect_o=0;
//    count_o=0.
//  - Pointers are ID_W bits. Storage index = ptr[ID_W-2:0].
//    count = bpu_ptr - comm_ptr (mod 2^ID_W).
//    full: count==DEPTH. empty: count==0.
//  - Invariant: comm_ptr <= ifu_ptr <= bpu_ptr, all in wrap-aware order.
//  - Enqueue: bpu_valid_i & bpu_ready_o writes the entry at bpu_ptr, then bpu_ptr+1.
//    bpu_valid_i while full is ignored and writes nothing.
//  - Override: bpu_ovr_valid_i with count>0 rewrites entry bpu_ptr-1, where bpu_ptr is the value
//    before any same-cycle enqueue.
//    - Same-cycle enqueue and override are both applied, to different entries.
//    - Override with count==0 is ignored.
//  - IFU: ifu_valid_o = (ifu_ptr != bpu_ptr). Data is read combinationally from registered storage.
//    ifu_ready_i & ifu_valid_o advances ifu_ptr by 1.
//  - Rewind: if an override targets entry bpu_ptr-1 and that entry has already been dispatched
//    (ifu_ptr == bpu_ptr) or is dispatched in that cycle:
//    - ifu_ptr <= bpu_ptr-1;
//    - ifu_redirect_o pulses high in the next cycle, for 1 cycle.
//  - Commit: n = popcount(commit_mask_i), clamped to ifu_ptr - comm_ptr. comm_ptr += n.
//    Retired entries are cleared. Commit and enqueue in the same cycle are both applied.
//  - Flush (highest priority; overrides enqueue, override and rewind that cycle):
//    - ifu_ptr and bpu_ptr <= flush_id_i+1.
//    - Entries after flush_id_i are invalidated.
//    - The commit in the same cycle still applies.
//    - ifu_redirect_o is not raised.
//    - A flush_id_i outside [comm_ptr, bpu_ptr) is a protocol violation; assert in simulation.
//  - Wrap: after 2*DEPTH enqueues and commits, pointers return to 0. Full and empty stay correct.
//  - Reset mid-operation: the next cycle equals the reset state, regardless of other inputs.
//  - Output timing:
//    - bpu_ready_o is a combinational function of registered pointers.
//    - count_o and ifu_* are registered-state-derived, with no input-to-output combinational path
//      except the read mux.
// TESTING (DEPTH=4, COMMIT_WIDTH=2)
//  1. 4 enqueues with no IFU or commit -> count_o=4, bpu_ready_o=0.
//     A 5th bpu_valid_i is dropped; count_o stays 4.
//  2. Enqueue PC 0x1000, IFU accepts it. Next cycle, override with PC 0x2000 ->
//     ifu_redirect_o pulses once; ifu_pc_o=0x2000; ifu_ftq_id_o=0.
//  3. 3 blocks dispatched, commit_mask_i=2'b11 -> comm_ptr=2, count_o=1.
//     Then commit_mask_i=2'b11 with 1 dispatched -> only 1 retired.
//  4. Enqueue ids 0..3, flush_i with flush_id_i=1 -> bpu_ptr=ifu_ptr=2, count_o=2.
//     Next enqueue lands at id 2.
//  5. Enqueue, dispatch and commit 10 blocks streaming -> ids wrap 7->0; count_o stays in 0..4.
//     Never full and empty at once.
//  6. rst asserted in the cycle after 3 enqueues -> next cycle count_o=0, ifu_valid_o=0,
//     bpu_ready_o=1.

Source files
------------

// File: rtl/ftq_multi_commit.sv
// Fetch target queue between BPU and IFU: wrap-bit pointers, youngest-entry override with IFU rewind,
// multi-slot in-order commit, backend flush. Zero-latency read mux; bpu_ready_o drops only when full.
module ftq_multi_commit #(
   parameter int DEPTH        = 8,
   parameter int ADDR_WIDTH   = 32,
   parameter int LEN_WIDTH    = 3,
   parameter int COMMIT_WIDTH = 2,
   localparam int ID_W        = $clog2(DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    bpu_valid_i,
   input  logic [ADDR_WIDTH-1:0]   bpu_pc_i,
   input  logic [LEN_WIDTH-1:0]    bpu_len_i,
   input  logic                    bpu_taken_i,
   output logic                    bpu_ready_o,
   input  logic                    bpu_ovr_valid_i,
   input  logic [ADDR_WIDTH-1:0]   bpu_ovr_pc_i,
   input  logic [LEN_WIDTH-1:0]    bpu_ovr_len_i,
   input  logic                    bpu_ovr_taken_i,
   output logic                    ifu_valid_o,
   output logic [ADDR_WIDTH-1:0]   ifu_pc_o,
   output logic [LEN_WIDTH-1:0]    ifu_len_o,
   output logic                    ifu_taken_o,
   output logic [ID_W-1:0]         ifu_ftq_id_o,
   input  logic                    ifu_ready_i,
   output logic                    ifu_redirect_o,
   input  logic [COMMIT_WIDTH-1:0] commit_mask_i,
   input  logic                    flush_i,
   input  logic [ID_W-1:0]         flush_id_i,
   output logic [ID_W-1:0]         count_o
);

   localparam int IDX_W = ID_W - 1;

   typedef struct packed {
      logic                  vld;
      logic [ADDR_WIDTH-1:0] pc;
      logic [LEN_WIDTH-1:0]  len;
      logic                  taken;
   } entry_t;

   entry_t          r_mem [DEPTH];
   logic [ID_W-1:0] r_bpu_ptr;
   logic [ID_W-1:0] r_ifu_ptr;
   logic [ID_W-1:0] r_comm_ptr;
   logic            r_redirect;

   entry_t          w_rd;
   entry_t          w_enq_ent;
   entry_t          w_ovr_ent;
   logic [ID_W-1:0] w_count;
   logic            w_full;
   logic            w_ptr_ne;
   logic            w_ifu_vld;
   logic            w_fire;
   logic            w_enq;
   logic            w_ovr;
   logic            w_rewind;
   logic [ID_W-1:0] w_ovr_ptr;
   logic [ID_W-1:0] w_flush_nxt;
   logic [ID_W-1:0] w_flush_span;
   logic [ID_W-1:0] w_ifu_nxt;
   logic [ID_W-1:0] w_bpu_nxt;
   logic [ID_W-1:0] w_ifu_off;
   logic [ID_W-1:0] w_nxt_off;
   logic [ID_W-1:0] w_pop;
   logic [ID_W-1:0] w_lim;
   logic [ID_W-1:0] w_n;
   logic [DEPTH-1:0] w_flush_kill;
   logic [DEPTH-1:0] w_comm_kill;
   logic [IDX_W-1:0] w_rel;
   logic [IDX_W-1:0] w_slot;

   assign w_count      = r_bpu_ptr - r_comm_ptr;
   assign w_full       = (w_count == ID_W'(DEPTH));
   assign w_rd         = r_mem[r_ifu_ptr[IDX_W-1:0]];
   assign w_ptr_ne     = (r_ifu_ptr != r_bpu_ptr);
   assign w_ifu_vld    = w_ptr_ne & w_rd.vld;
   assign w_fire       = ifu_ready_i & w_ifu_vld;
   assign w_enq        = bpu_valid_i & ~w_full;
   assign w_ovr        = bpu_ovr_valid_i & (w_count != '0);
   assign w_ovr_ptr    = r_bpu_ptr - ID_W'(1);
   assign w_flush_nxt  = flush_id_i + ID_W'(1);
   assign w_flush_span = r_bpu_ptr - w_flush_nxt;
   assign w_enq_ent    = {1'b1, bpu_pc_i, bpu_len_i, bpu_taken_i};
   assign w_ovr_ent    = {1'b1, bpu_ovr_pc_i, bpu_ovr_len_i, bpu_ovr_taken_i};

   // Rewind when the overridden entry is already with the IFU or leaves for it this cycle.
   assign w_rewind = w_ovr & ~flush_i & (~w_ptr_ne | (w_fire & (r_ifu_ptr == w_ovr_ptr)));

   always_comb begin
      w_ifu_nxt = r_ifu_ptr;
      if (flush_i)
         w_ifu_nxt = w_flush_nxt;
      else if (w_rewind)
         w_ifu_nxt = w_ovr_ptr;
      else if (w_fire)
         w_ifu_nxt = r_ifu_ptr + ID_W'(1);
   end

   assign w_bpu_nxt = flush_i ? w_flush_nxt : r_bpu_ptr + ID_W'(w_enq);
   assign w_ifu_off = r_ifu_ptr - r_comm_ptr;
   assign w_nxt_off = w_ifu_nxt - r_comm_ptr;

   // Commit never passes the IFU pointer, including where it lands after a flush or rewind.
   always_comb begin
      w_pop = '0;
      for (int k = 0; k < COMMIT_WIDTH; k++)
         w_pop = w_pop + ID_W'(commit_mask_i[k]);
      w_lim = (w_nxt_off < w_ifu_off) ? w_nxt_off : w_ifu_off;
      w_n   = (w_pop < w_lim) ? w_pop : w_lim;
   end

   always_comb begin
      w_flush_kill = '0;
      w_comm_kill  = '0;
      w_rel        = '0;
      w_slot       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_rel           = IDX_W'(i) - w_flush_nxt[IDX_W-1:0];
         w_flush_kill[i] = flush_i & ({1'b0, w_rel} < w_flush_span);
      end
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         w_slot = r_comm_ptr[IDX_W-1:0] + IDX_W'(k);
         if (ID_W'(k) < w_n)
            w_comm_kill[w_slot] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bpu_ptr  <= '0;
         r_ifu_ptr  <= '0;
         r_comm_ptr <= '0;
         r_redirect <= 1'b0;
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
      end else begin
         r_bpu_ptr  <= w_bpu_nxt;
         r_ifu_ptr  <= w_ifu_nxt;
         r_comm_ptr <= r_comm_ptr + w_n;
         r_redirect <= w_rewind;
         if (!flush_i) begin
            if (w_enq)
               r_mem[r_bpu_ptr[IDX_W-1:0]] <= w_enq_ent;
            if (w_ovr)
               r_mem[w_ovr_ptr[IDX_W-1:0]] <= w_ovr_ent;
         end
         for (int i = 0; i < DEPTH; i++)
            if (w_flush_kill[i] || w_comm_kill[i])
               r_mem[i].vld <= 1'b0;
      end
   end

   assign bpu_ready_o    = ~w_full;
   assign ifu_valid_o    = w_ifu_vld;
   assign ifu_pc_o       = w_rd.pc;
   assign ifu_len_o      = w_rd.len;
   assign ifu_taken_o    = w_rd.taken;
   assign ifu_ftq_id_o   = r_ifu_ptr;
   assign ifu_redirect_o = r_redirect;
   assign count_o        = w_count;

`ifndef SYNTHESIS
   logic [ID_W-1:0] w_flush_off;
   assign w_flush_off = flush_id_i - r_comm_ptr;

   always_ff @(posedge clk) begin
      if (!rst && flush_i)
         assert (w_flush_off < w_count)
            else $error("ftq_multi_commit: flush_id_i outside the live range");
   end
`endif

endmodule

// File: tb/tb_ftq_multi_commit.sv
// Scoreboard bench for ftq_multi_commit at DEPTH=4, COMMIT_WIDTH=2.
module tb_ftq_multi_commit;
   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int LW    = 3;
   localparam int CW    = 2;
   localparam int IDW   = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic           bpu_valid_i;
   logic [AW-1:0]  bpu_pc_i;
   logic [LW-1:0]  bpu_len_i;
   logic           bpu_taken_i;
   logic           bpu_ready_o;
   logic           bpu_ovr_valid_i;
   logic [AW-1:0]  bpu_ovr_pc_i;
   logic [LW-1:0]  bpu_ovr_len_i;
   logic           bpu_ovr_taken_i;
   logic           ifu_valid_o;
   logic [AW-1:0]  ifu_pc_o;
   logic [LW-1:0]  ifu_len_o;
   logic           ifu_taken_o;
   logic [IDW-1:0] ifu_ftq_id_o;
   logic           ifu_ready_i;
   logic           ifu_redirect_o;
   logic [CW-1:0]  commit_mask_i;
   logic           flush_i;
   logic [IDW-1:0] flush_id_i;
   logic [IDW-1:0] count_o;

   always #5 clk = ~clk;

   ftq_multi_commit #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .COMMIT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .bpu_valid_i(bpu_valid_i), .bpu_pc_i(bpu_pc_i), .bpu_len_i(bpu_len_i),
      .bpu_taken_i(bpu_taken_i), .bpu_ready_o(bpu_ready_o),
      .bpu_ovr_valid_i(bpu_ovr_valid_i), .bpu_ovr_pc_i(bpu_ovr_pc_i),
      .bpu_ovr_len_i(bpu_ovr_len_i), .bpu_ovr_taken_i(bpu_ovr_taken_i),
      .ifu_valid_o(ifu_valid_o), .ifu_pc_o(ifu_pc_o), .ifu_len_o(ifu_len_o),
      .ifu_taken_o(ifu_taken_o), .ifu_ftq_id_o(ifu_ftq_id_o), .ifu_ready_i(ifu_ready_i),
      .ifu_redirect_o(ifu_redirect_o), .commit_mask_i(commit_mask_i),
      .flush_i(flush_i), .flush_id_i(flush_id_i), .count_o(count_o)
   );

   typedef struct {
      int            seq;
      logic [AW-1:0] pc;
      logic [LW-1:0] len;
      logic          tk;
   } exp_t;

   exp_t sb_q[$];
   int   m_bpu, m_ifu, m_comm;
   int   flush_seq;
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bpu_valid_i     = 1'b0;
      bpu_pc_i        = '0;
      bpu_len_i       = '0;
      bpu_taken_i     = 1'b0;
      bpu_ovr_valid_i = 1'b0;
      bpu_ovr_pc_i    = '0;
      bpu_ovr_len_i   = '0;
      bpu_ovr_taken_i = 1'b0;
      ifu_ready_i     = 1'b0;
      commit_mask_i   = '0;
      flush_i         = 1'b0;
      flush_id_i      = '0;
   endtask

   // One clock: compare pre-edge outputs, update the reference, advance, check redirect.
   task automatic cyc();
      bit   fire, enq, ovr, rew;
      int   cnt, n, tgt;
      exp_t e;
      cnt = m_bpu - m_comm;
      check("count", count_o, cnt);
      check("bpu_ready", bpu_ready_o, cnt != DEPTH);
      check("ifu_valid", ifu_valid_o, m_ifu != m_bpu);
      fire = ifu_ready_i && (m_ifu != m_bpu);
      if (fire && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check("ifu_pc", ifu_pc_o, e.pc);
         check("ifu_len", ifu_len_o, e.len);
         check("ifu_taken", ifu_taken_o, e.tk);
         check("ifu_id", ifu_ftq_id_o, e.seq & 7);
      end
      enq = bpu_valid_i && cnt != DEPTH;
      ovr = bpu_ovr_valid_i && cnt != 0;
      rew = 1'b0;
      n   = $countones(commit_mask_i);
      if (n > m_ifu - m_comm) n = m_ifu - m_comm;
      if (flush_i) begin
         m_comm += n;
         m_bpu   = flush_seq + 1;
         m_ifu   = m_bpu;
         sb_q.delete();
      end else begin
         tgt = m_bpu - 1;
         if (ovr) begin
            e = '{seq: tgt, pc: bpu_ovr_pc_i, len: bpu_ovr_len_i, tk: bpu_ovr_taken_i};
            if (m_ifu == m_bpu || (fire && m_ifu == tgt)) begin
               rew = 1'b1;
               sb_q.push_back(e);
            end else begin
               sb_q[sb_q.size()-1] = e;
            end
         end
         if (enq)
            sb_q.push_back('{seq: m_bpu, pc: bpu_pc_i, len: bpu_len_i, tk: bpu_taken_i});
         m_comm += n;
         if (rew) m_ifu = tgt;
         else if (fire) m_ifu++;
         if (enq) m_bpu++;
      end
      tick();
      check("redirect", ifu_redirect_o, rew);
      idle();
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_bpu = 0; m_ifu = 0; m_comm = 0;
      sb_q.delete();
      check("rst_count", count_o, 0);
      check("rst_ready", bpu_ready_o, 1);
      check("rst_ifu_valid", ifu_valid_o, 0);
      check("rst_redirect", ifu_redirect_o, 0);
   endtask

   task automatic enq(input logic [AW-1:0] pc, input logic [LW-1:0] len, input logic tk);
      bpu_valid_i = 1'b1;
      bpu_pc_i    = pc;
      bpu_len_i   = len;
      bpu_taken_i = tk;
      cyc();
   endtask

   task automatic dispatch(input int k);
      for (int i = 0; i < k; i++) begin
         ifu_ready_i = 1'b1;
         cyc();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int nenq;
      idle();
      rst = 1'b1;
      tick();
      do_reset();

      // Fill to full; a fifth enqueue is dropped.
      for (int i = 0; i < 4; i++) enq(32'h100 + 32'(i * 4), LW'(i), i[0]);
      check("t1_count_full", count_o, 4);
      check("t1_ready_full", bpu_ready_o, 0);
      enq(32'hDEAD, 3'd7, 1'b1);
      check("t1_count_drop", count_o, 4);
      dispatch(4);

      // Override of a dispatched entry rewinds the IFU.
      do_reset();
      enq(32'h1000, 3'd2, 1'b0);
      dispatch(1);
      bpu_ovr_valid_i = 1'b1; bpu_ovr_pc_i = 32'h2000; bpu_ovr_len_i = 3'd5; bpu_ovr_taken_i = 1'b1;
      cyc();
      check("t2_pc", ifu_pc_o, 32'h2000);
      check("t2_id", ifu_ftq_id_o, 0);
      cyc();
      dispatch(1);

      // Override on an empty queue is ignored; override of a queued entry beside an enqueue.
      do_reset();
      bpu_ovr_valid_i = 1'b1; bpu_ovr_pc_i = 32'h3000;
      cyc();
      enq(32'hA000, 3'd1, 1'b0);
      bpu_ovr_valid_i = 1'b1; bpu_ovr_pc_i = 32'hA100; bpu_ovr_len_i = 3'd3; bpu_ovr_taken_i = 1'b1;
      enq(32'hB000, 3'd4, 1'b0);
      check("t7_count", count_o, 2);
      dispatch(2);
      // Override in the very cycle the entry is dispatched.
      enq(32'hC000, 3'd6, 1'b0);
      ifu_ready_i = 1'b1;
      bpu_ovr_valid_i = 1'b1; bpu_ovr_pc_i = 32'hC100; bpu_ovr_len_i = 3'd1; bpu_ovr_taken_i = 1'b1;
      cyc();
      check("t7_rew_pc", ifu_pc_o, 32'hC100);
      dispatch(1);

      // Multi-commit with clamping to dispatched entries.
      do_reset();
      for (int i = 0; i < 3; i++) enq(32'h5000 + 32'(i * 16), LW'(i + 1), 1'b0);
      dispatch(3);
      commit_mask_i = 2'b11;
      cyc();
      check("t3_count_a", count_o, 1);
      commit_mask_i = 2'b11;
      cyc();
      check("t3_count_b", count_o, 0);
      check("t3_ready", bpu_ready_o, 1);

      // Flush to id 1 keeps entries 0..1; the next block gets id 2.
      do_reset();
      for (int i = 0; i < 4; i++) enq(32'h6000 + 32'(i * 8), LW'(i), 1'b1);
      flush_i = 1'b1; flush_id_i = 3'd1; flush_seq = 1;
      cyc();
      check("t4_count", count_o, 2);
      check("t4_ifu_id", ifu_ftq_id_o, 2);
      enq(32'h4444, 3'd5, 1'b0);
      dispatch(1);

      // Streaming enqueue, dispatch and commit across the pointer wrap.
      do_reset();
      nenq = 0;
      for (int c = 0; c < 18; c++) begin
         if (nenq < 10 && bpu_ready_o) begin
            bpu_valid_i = 1'b1;
            bpu_pc_i    = 32'h8000 + 32'(nenq * 4);
            bpu_len_i   = LW'(nenq);
            bpu_taken_i = nenq[1];
            nenq++;
         end
         ifu_ready_i   = 1'b1;
         commit_mask_i = (c % 3 == 0) ? 2'b11 : 2'b01;
         cyc();
         check("t5_range", count_o <= 3'd4, 1);
         check("t5_full_empty", !bpu_ready_o && count_o == 0, 0);
      end
      check("t5_drained", count_o, 0);

      // Reset mid-operation overrides all other inputs.
      do_reset();
      for (int i = 0; i < 3; i++) enq(32'h9000 + 32'(i), 3'd1, 1'b0);
      rst = 1'b1;
      bpu_valid_i = 1'b1; bpu_pc_i = 32'h9999; ifu_ready_i = 1'b1; commit_mask_i = 2'b11;
      bpu_ovr_valid_i = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      check("t6_count", count_o, 0);
      check("t6_ifu_valid", ifu_valid_o, 0);
      check("t6_ready", bpu_ready_o, 1);
      check("t6_redirect", ifu_redirect_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
